// File: rtl/z2_bus_initiator.sv
// Zorro II / 68000-style single-cycle bus master: arbitrates via BR_n/BG_n/BGACK_n,
// runs one read or write, then releases the bus. Optional S_WAIT timeout: Z2M_TIMEOUT_EN.
module z2_bus_initiator #(
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned HOLD_CYC   = 1
`ifdef Z2M_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
  input  logic        MEMCLK,
  input  logic        RESET_n,
  input  logic        req,
  input  logic        req_rw,
  input  logic [22:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [1:0]  req_be,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] rdata,
  output logic        BR_n,
  input  logic        BG_n,
  input  logic        BGACK_n_i,
  output logic        BGACK_n_o,
  output logic        BGACK_oe,
  input  logic        AS_n_i,
  input  logic        DTACK_n,
  input  logic        BERR_n,
  output logic        bus_oe,
  output logic [22:0] ADDR_O,
  output logic        AS_n_o,
  output logic        UDS_n,
  output logic        LDS_n,
  output logic        RW_o,
  output logic [15:0] D_O,
  output logic        D_oe,
  input  logic [15:0] D_I
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_ARB    = 4'd1;
  localparam logic [3:0] S_ADDR   = 4'd2;
  localparam logic [3:0] S_WSTB   = 4'd3;
  localparam logic [3:0] S_WAIT   = 4'd4;
  localparam logic [3:0] S_SETTLE = 4'd5;
  localparam logic [3:0] S_TERM   = 4'd6;
  localparam logic [3:0] S_REL    = 4'd7;

  localparam logic [7:0] SettleLast = (SETTLE_CYC > 1) ? 8'(SETTLE_CYC - 1) : 8'd0;
  localparam logic [7:0] HoldLast   = (HOLD_CYC > 1) ? 8'(HOLD_CYC - 1) : 8'd0;
`ifdef Z2M_TIMEOUT_EN
  localparam logic [7:0] TmoLast    = 8'(TIMEOUT_CYC - 1);
  logic [7:0] tmo_q, tmo_d;
`endif

  // Sync vector order: {BG_n, BGACK_n_i, AS_n_i, DTACK_n, BERR_n}; resets to idle-high.
  logic [4:0]  meta_q, meta_d, sync_q, sync_d;
  logic        bg_s, bgack_s, as_s, dtack_s, berr_s;

  logic [3:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [22:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]  be_q, be_d;
  logic        rw_q, rw_d, rw_o_q, rw_o_d;
  logic        br_n_q, br_n_d, bgack_n_q, bgack_n_d, bgack_oe_q, bgack_oe_d;
  logic        bus_oe_q, bus_oe_d, d_oe_q, d_oe_d;
  logic        as_n_q, as_n_d, uds_n_q, uds_n_d, lds_n_q, lds_n_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic        strobe_off;

  assign meta_d = {BG_n, BGACK_n_i, AS_n_i, DTACK_n, BERR_n};
  assign sync_d = meta_q;
  assign {bg_s, bgack_s, as_s, dtack_s, berr_s} = sync_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    be_d       = be_q;
    rw_d       = rw_q;
    rw_o_d     = rw_o_q;
    br_n_d     = br_n_q;
    bgack_n_d  = bgack_n_q;
    bgack_oe_d = bgack_oe_q;
    bus_oe_d   = bus_oe_q;
    d_oe_d     = d_oe_q;
    as_n_d     = as_n_q;
    uds_n_d    = uds_n_q;
    lds_n_d    = lds_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    strobe_off = 1'b0;
`ifdef Z2M_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (req_be == 2'b00) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            addr_d  = req_addr;
            wdata_d = req_wdata;
            be_d    = req_be;
            rw_d    = req_rw;
            busy_d  = 1'b1;
            err_d   = 1'b0;
            br_n_d  = 1'b0;
            state_d = S_ARB;
          end
        end
      end
      S_ARB: begin
        // Only take the bus once the previous master has fully finished its cycle.
        if (!bg_s && as_s && bgack_s && dtack_s) begin
          bgack_oe_d = 1'b1;
          bgack_n_d  = 1'b0;
          br_n_d     = 1'b1;
          bus_oe_d   = 1'b1;
          rw_o_d     = rw_q;
          state_d    = S_ADDR;
        end
      end
      S_ADDR: begin
        as_n_d = 1'b0;
        if (rw_q) begin
          uds_n_d = ~be_q[1];
          lds_n_d = ~be_q[0];
          state_d = S_WAIT;
`ifdef Z2M_TIMEOUT_EN
          tmo_d   = 8'd0;
`endif
        end else begin
          d_oe_d  = 1'b1;
          state_d = S_WSTB;
        end
      end
      S_WSTB: begin
        uds_n_d = ~be_q[1];
        lds_n_d = ~be_q[0];
        state_d = S_WAIT;
`ifdef Z2M_TIMEOUT_EN
        tmo_d   = 8'd0;
`endif
      end
      S_WAIT: begin
        if (!berr_s) begin
          err_d      = 1'b1;
          strobe_off = 1'b1;
          cnt_d      = 8'd0;
          state_d    = S_TERM;
        end else if (!dtack_s) begin
          cnt_d = 8'd0;
          if (SETTLE_CYC == 0) begin
            if (rw_q) rdata_d = D_I;
            strobe_off = 1'b1;
            state_d    = S_TERM;
          end else begin
            state_d = S_SETTLE;
          end
`ifdef Z2M_TIMEOUT_EN
        end else if (tmo_q == TmoLast) begin
          err_d      = 1'b1;
          strobe_off = 1'b1;
          cnt_d      = 8'd0;
          state_d    = S_TERM;
        end else begin
          tmo_d = tmo_q + 8'd1;
`endif
        end
      end
      S_SETTLE: begin
        if (cnt_q == SettleLast) begin
          if (rw_q) rdata_d = D_I;
          strobe_off = 1'b1;
          cnt_d      = 8'd0;
          state_d    = S_TERM;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_TERM: begin
        if (cnt_q == HoldLast) begin
          bus_oe_d  = 1'b0;
          d_oe_d    = 1'b0;
          bgack_n_d = 1'b1;
          state_d   = S_REL;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_REL: begin
        bgack_oe_d = 1'b0;
        rw_o_d     = 1'b1;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (strobe_off) begin
      as_n_d  = 1'b1;
      uds_n_d = 1'b1;
      lds_n_d = 1'b1;
    end
  end

  always_ff @(posedge MEMCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      meta_q     <= 5'h1f;
      sync_q     <= 5'h1f;
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      addr_q     <= 23'd0;
      wdata_q    <= 16'd0;
      rdata_q    <= 16'd0;
      be_q       <= 2'b00;
      rw_q       <= 1'b1;
      rw_o_q     <= 1'b1;
      br_n_q     <= 1'b1;
      bgack_n_q  <= 1'b1;
      bgack_oe_q <= 1'b0;
      bus_oe_q   <= 1'b0;
      d_oe_q     <= 1'b0;
      as_n_q     <= 1'b1;
      uds_n_q    <= 1'b1;
      lds_n_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef Z2M_TIMEOUT_EN
      tmo_q      <= 8'd0;
`endif
    end else begin
      meta_q     <= meta_d;
      sync_q     <= sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      be_q       <= be_d;
      rw_q       <= rw_d;
      rw_o_q     <= rw_o_d;
      br_n_q     <= br_n_d;
      bgack_n_q  <= bgack_n_d;
      bgack_oe_q <= bgack_oe_d;
      bus_oe_q   <= bus_oe_d;
      d_oe_q     <= d_oe_d;
      as_n_q     <= as_n_d;
      uds_n_q    <= uds_n_d;
      lds_n_q    <= lds_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef Z2M_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign BR_n      = br_n_q;
  assign BGACK_n_o = bgack_n_q;
  assign BGACK_oe  = bgack_oe_q;
  assign bus_oe    = bus_oe_q;
  assign ADDR_O    = addr_q;
  assign AS_n_o    = as_n_q;
  assign UDS_n     = uds_n_q;
  assign LDS_n     = lds_n_q;
  assign RW_o      = rw_o_q;
  assign D_O       = wdata_q;
  assign D_oe      = d_oe_q;

endmodule

// File: tb/tb_z2_bus_initiator.sv
// Directed bench for z2_bus_initiator: read, write, BERR, arbitration hold-off,
// async reset, bad request and S_WAIT timeout (Z2M_TIMEOUT_EN) or indefinite wait.
module tb_z2_bus_initiator;

  logic        MEMCLK, RESET_n;
  logic        req, req_rw;
  logic [22:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        busy, done, err;
  logic [15:0] rdata;
  logic        BR_n, BG_n, BGACK_n_i, BGACK_n_o, BGACK_oe;
  logic        AS_n_i, DTACK_n, BERR_n, bus_oe;
  logic [22:0] ADDR_O;
  logic        AS_n_o, UDS_n, LDS_n, RW_o, D_oe;
  logic [15:0] D_O, D_I;

  int checks   = 0;
  int failures = 0;

  z2_bus_initiator #(
    .SETTLE_CYC(1),
    .HOLD_CYC(1)
`ifdef Z2M_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(16)
`endif
  ) dut (
    .MEMCLK(MEMCLK), .RESET_n(RESET_n), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .BR_n(BR_n), .BG_n(BG_n), .BGACK_n_i(BGACK_n_i), .BGACK_n_o(BGACK_n_o),
    .BGACK_oe(BGACK_oe), .AS_n_i(AS_n_i), .DTACK_n(DTACK_n), .BERR_n(BERR_n),
    .bus_oe(bus_oe), .ADDR_O(ADDR_O), .AS_n_o(AS_n_o), .UDS_n(UDS_n), .LDS_n(LDS_n),
    .RW_o(RW_o), .D_O(D_O), .D_oe(D_oe), .D_I(D_I)
  );

  initial MEMCLK = 1'b0;
  always #5 MEMCLK = ~MEMCLK;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge MEMCLK);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    RESET_n = 1'b0; req = 1'b0; req_rw = 1'b1; req_addr = '0; req_wdata = '0; req_be = '0;
    BG_n = 1'b1; BGACK_n_i = 1'b1; AS_n_i = 1'b1; DTACK_n = 1'b1; BERR_n = 1'b1; D_I = '0;
    #12;
    check("rst_br_n", BR_n, 1); check("rst_bgack_oe", BGACK_oe, 0);
    check("rst_bgack_n", BGACK_n_o, 1); check("rst_bus_oe", bus_oe, 0);
    check("rst_d_oe", D_oe, 0); check("rst_strobes", {AS_n_o, UDS_n, LDS_n, RW_o}, 4'hf);
    check("rst_status", {busy, done, err}, 0); check("rst_rdata", rdata, 0);
    RESET_n = 1'b1;
    tick(2);

    // Read word 0xE80000, both lanes
    req = 1; req_rw = 1; req_addr = 23'h740000; req_be = 2'b11;
    tick();
    req = 0;
    check("rd_br_assert", BR_n, 0); check("rd_busy", busy, 1);
    tick(3);
    check("rd_no_grant_yet", BGACK_oe, 0);
    BG_n = 0;
    tick(2);
    check("rd_grant_sync", BGACK_oe, 0);
    tick();
    check("rd_bgack_oe", BGACK_oe, 1); check("rd_bgack_n", BGACK_n_o, 0);
    check("rd_br_release", BR_n, 1); check("rd_bus_oe", bus_oe, 1);
    check("rd_addr", ADDR_O, 23'h740000); check("rd_rw", RW_o, 1); check("rd_as_pre", AS_n_o, 1);
    tick();
    check("rd_strobes", {AS_n_o, UDS_n, LDS_n}, 3'b000); check("rd_d_oe", D_oe, 0);
    tick(3);
    DTACK_n = 0; D_I = 16'hA5C3;
    tick(3);
    check("rd_settle_as", AS_n_o, 0);
    tick();
    check("rd_term_strobes", {AS_n_o, UDS_n, LDS_n}, 3'b111);
    check("rd_rdata", rdata, 16'hA5C3); check("rd_term_oe", bus_oe, 1);
    tick();
    check("rd_rel", {bus_oe, BGACK_n_o, BGACK_oe, done}, 4'b0110);
    tick();
    check("rd_done", {done, err, busy, BGACK_oe}, 4'b1000);
    tick();
    check("rd_done_pulse", done, 0); check("rd_rdata_hold", rdata, 16'hA5C3);
    DTACK_n = 1; D_I = '0;
    tick(3);

    // Write 0x200002, upper lane only
    req = 1; req_rw = 0; req_addr = 23'h100001; req_be = 2'b10; req_wdata = 16'h12FF;
    tick();
    req = 0;
    tick();
    check("wr_rw", RW_o, 0); check("wr_bus_oe", bus_oe, 1);
    check("wr_addr", ADDR_O, 23'h100001); check("wr_d_oe_pre", D_oe, 0);
    tick();
    check("wr_as", {AS_n_o, UDS_n, LDS_n}, 3'b011); check("wr_d_oe", D_oe, 1);
    check("wr_data", D_O, 16'h12FF);
    tick();
    check("wr_uds", {AS_n_o, UDS_n, LDS_n}, 3'b001);
    DTACK_n = 0;
    tick(4);
    check("wr_term", {UDS_n, D_oe}, 2'b11); check("wr_rdata_kept", rdata, 16'hA5C3);
    tick();
    check("wr_rel", {D_oe, bus_oe}, 2'b00);
    tick();
    check("wr_done", {done, err, busy}, 3'b100);
    DTACK_n = 1;
    tick(3);

    // BERR and DTACK together, lower lane read
    req = 1; req_rw = 1; req_addr = 23'h000010; req_be = 2'b01;
    tick();
    req = 0;
    tick(2);
    check("be_lds_only", {UDS_n, LDS_n}, 2'b10);
    DTACK_n = 0; BERR_n = 0; D_I = 16'hBEEF;
    tick(3);
    check("be_term", {AS_n_o, UDS_n, LDS_n}, 3'b111); check("be_err", err, 1);
    check("be_rdata", rdata, 16'hA5C3);
    tick();
    check("be_rel", bus_oe, 0);
    tick();
    check("be_done", {done, err, busy, BGACK_oe}, 4'b1100);
    check("be_rdata_after", rdata, 16'hA5C3);
    DTACK_n = 1; BERR_n = 1; D_I = '0;
    tick(3);

    // Foreign AS_n held low blocks takeover
    AS_n_i = 0;
    tick(3);
    req = 1; req_rw = 1; req_addr = 23'h000005; req_be = 2'b11;
    tick();
    req = 0;
    tick(5);
    check("as_block_bgack", BGACK_oe, 0); check("as_block_br", BR_n, 0);
    AS_n_i = 1;
    tick(2);
    check("as_sync_bgack", BGACK_oe, 0);
    tick();
    check("as_grant", BGACK_oe, 1);
    tick(2);
    check("as_wait", {bus_oe, AS_n_o}, 2'b10);

    // Asynchronous reset mid S_WAIT
    #2 RESET_n = 0;
    #1;
    check("arst_oe", {bus_oe, BGACK_oe, D_oe}, 3'b000);
    check("arst_br", {BR_n, AS_n_o, busy}, 3'b110);
    #1 RESET_n = 1;
    tick(2);

    // Zero byte enables
    req = 1; req_rw = 1; req_addr = 23'h000006; req_be = 2'b00;
    tick();
    check("bad_done", {done, err, busy, BR_n}, 4'b1101);
    req = 0;
    tick();
    check("bad_after", {done, BR_n}, 2'b01);

    // No DTACK ever
    req = 1; req_rw = 1; req_addr = 23'h000007; req_be = 2'b11;
    tick();
    req = 0;
    tick(2);
    check("to_wait", AS_n_o, 0);
`ifdef Z2M_TIMEOUT_EN
    tick(15);
    check("to_pre", {AS_n_o, err}, 2'b00);
    tick();
    check("to_term", {AS_n_o, err}, 2'b11);
    tick(2);
    check("to_done", {done, err, busy}, 3'b110);
`else
    tick(1000);
    check("no_to_busy", {busy, AS_n_o, done}, 3'b100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
